rocca_s_deadlock_reporter: RTL and testbench
============================================

Name: rocca_s_deadlock_reporter

Overview:
Consumer end of the HLS deadlock monitor's block indication. It qualifies the monitor's one-bit block output with a persistence timeout, so a transient stall is never reported. On a confirmed deadlock it captures a snapshot of the per-channel AXIS block and instance idle vectors, then emits one report word over a valid/ready interface to the status/debug path. It also raises a sticky deadlock flag for the top-level control logic.

Parameters:
NUM_AXIS, 5, number of AXIS block signals snapshotted
NUM_INST, 4, number of instance idle signals snapshotted
TIMEOUT, 1024, consecutive block cycles required to confirm a deadlock; legal range 2..65535
CNT_W, 16, persistence counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
block_in  in  1  block output from the deadlock monitor
axis_block_sigs  in  NUM_AXIS  per-channel AXIS block vector
inst_idle_sigs  in  NUM_INST  per-instance idle vector
clear  in  1  software clear of the sticky flag and of the re-arm hold
report_valid  out  1  report word available
report_ready  in  1  downstream accepts the report
report_data  out  NUM_AXIS+NUM_INST+8  {seq[7:0], inst_idle snapshot, axis_block snapshot}; LSBs hold axis_block
deadlock_flag  out  1  sticky; set on confirmed deadlock
state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset and clock: reset and clock exactly as already decided (reset: synchronous, active-high; clock: clock).
- Reset values: report_valid=0, report_data=0, deadlock_flag=0, state=IDLE (state_dbg=0), counter=0, seq=0.
- FSM states: IDLE=0, COUNT=1, REPORT=2, HOLD=3.
- IDLE:
  - Edge with block_in=1: go to COUNT, cnt<=1.
  - Otherwise stay in IDLE.
- COUNT:
  - Edge with block_in=0: go to IDLE, cnt<=0.
  - Edge with block_in=1 and cnt==TIMEOUT-1: go to REPORT. On the same edge:
    - capture axis_block_sigs and inst_idle_sigs into report_data, with the current seq value;
    - set report_valid<=1 and deadlock_flag<=1;
    - set seq<=seq+1.
  - Edge with block_in=1 otherwise: cnt<=cnt+1.
- Latency: report_valid first reads high in the cycle after the TIMEOUT-th consecutive edge that samples block_in=1.
- REPORT:
  - report_valid stays high and report_data stays stable until an edge with report_valid&report_ready.
  - On that handshake: report_valid<=0, go to HOLD.
  - block_in and clear have no effect on the pending report; valid never drops without a handshake.
- HOLD:
  - Edge with block_in=0 or clear=1: go to IDLE, cnt<=0.
  - Otherwise stay in HOLD. This guarantees exactly one report per deadlock episode.
- deadlock_flag:
  - Cleared by clear=1 in any state except on the edge that enters REPORT; on that edge set wins over clear.
  - Otherwise holds its value.
- seq: 8-bit, wraps 255->0; it is not reset by clear.
- Counter: cnt is never compared above TIMEOUT-1 and never overflows.
- report_data holds its last value when report_valid=0.
- Reset asserted mid-operation (any state, including REPORT with a pending report): all registers return to their reset values on the next edge and the pending report is dropped.

Decomposition:
- Shared package rocca_s_dbg_pkg holds:
  - the state encoding constants (IDLE/COUNT/REPORT/HOLD);
  - the report field offsets and widths (AXIS_LSB, IDLE_LSB, SEQ_LSB, SEQ_W=8);
  - the default TIMEOUT value.
- One sub-module is natural: rocca_s_persist_counter. It contains the saturating persistence counter, with a clear input, an increment input and a terminal-count output at TIMEOUT-1.
- The FSM and the report register stay in the top module.

Test Plan:
All scenarios use TIMEOUT=8.
1. Reset asserted for 3 cycles -> report_valid=0, deadlock_flag=0, state_dbg=0, report_data=0.
2. block_in high 7 cycles, then low -> no report; state returns to IDLE; deadlock_flag=0.
3. block_in held high with axis_block_sigs=5'b01000, inst_idle_sigs=4'b0011, report_ready=1 -> report_valid high exactly 1 cycle, after the 8th sampled-high edge; report_data={8'h00,4'b0011,5'b01000}; deadlock_flag=1; state_dbg then 3.
4. Same as scenario 3 but report_ready=0 for 20 cycles, with block_in dropped and clear pulsed during the wait -> report_valid stays 1 and report_data stays unchanged; handshake on the 21st cycle -> state goes to HOLD, then to IDLE because block_in=0.
5. Run 257 deadlock episodes, each followed by block_in low -> seq field reads 0..255, then 0 on the 257th report.
6. Reset pulsed while in REPORT with report_valid=1 -> next cycle report_valid=0, state_dbg=0, deadlock_flag=0, seq=0.

Source files
------------

// File: rtl/rocca_s_dbg_pkg.sv
// Shared definitions for the deadlock reporter: FSM encoding, report word layout, defaults.
package rocca_s_dbg_pkg;

    // FSM encoding; the numeric values are visible on state_dbg
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCount  = 2'd1,
        StReport = 2'd2,
        StHold   = 2'd3
    } dbg_state_t;

    // Report word layout: {seq, inst_idle snapshot, axis_block snapshot}, axis_block at the LSBs
    localparam int unsigned SEQ_W        = 8;
    localparam int unsigned AXIS_LSB     = 0;
    localparam int unsigned DEF_NUM_AXIS = 5;
    localparam int unsigned DEF_NUM_INST = 4;
    localparam int unsigned DEF_TIMEOUT  = 1024;

    // Field offsets for the default channel counts
    localparam int unsigned IDLE_LSB = AXIS_LSB + DEF_NUM_AXIS;
    localparam int unsigned SEQ_LSB  = IDLE_LSB + DEF_NUM_INST;

    // Field offsets for arbitrary channel counts
    function automatic int unsigned idle_lsb(input int unsigned num_axis);
        return AXIS_LSB + num_axis;
    endfunction

    function automatic int unsigned seq_lsb(input int unsigned num_axis,
                                            input int unsigned num_inst);
        return AXIS_LSB + num_axis + num_inst;
    endfunction

endpackage

// File: rtl/rocca_s_persist_counter.sv
// Saturating persistence counter; flags terminal count at TIMEOUT-1.
module rocca_s_persist_counter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    // Count up on incr, stop at terminal count so the counter can never wrap
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr && (count != TC_VAL)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal count is decoded from the registered value
    always_comb begin
        term = (count == TC_VAL);
    end

endmodule

// File: rtl/rocca_s_deadlock_reporter.sv
// Qualifies the deadlock monitor's block output with a persistence timeout, snapshots the
// block/idle vectors on a confirmed deadlock, and emits one report word per episode.
module rocca_s_deadlock_reporter
    import rocca_s_dbg_pkg::*;
#(
    parameter int unsigned NUM_AXIS = 5,
    parameter int unsigned NUM_INST = 4,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               block_in,
    input  logic [NUM_AXIS-1:0]                axis_block_sigs,
    input  logic [NUM_INST-1:0]                inst_idle_sigs,
    input  logic                               clear,
    output logic                               report_valid,
    input  logic                               report_ready,
    output logic [NUM_AXIS+NUM_INST+SEQ_W-1:0] report_data,
    output logic                               deadlock_flag,
    output logic [1:0]                         state_dbg
);

    localparam int unsigned I_LSB = idle_lsb(NUM_AXIS);
    localparam int unsigned S_LSB = seq_lsb(NUM_AXIS, NUM_INST);

    dbg_state_t       state;
    logic [SEQ_W-1:0] seq;
    logic             cnt_incr;
    logic             cnt_clear;
    logic             cnt_term;
    logic [CNT_W-1:0] cnt;

    // Counter runs only while a block run is being qualified; any other cycle zeroes it
    always_comb begin
        cnt_incr  = block_in && ((state == StIdle) || (state == StCount));
        cnt_clear = !cnt_incr;
    end

    rocca_s_persist_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_persist (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .count (cnt),
        .term  (cnt_term)
    );

    // Main FSM with registered report, sticky flag and sequence number
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= StIdle;
            report_valid  <= 1'b0;
            report_data   <= '0;
            deadlock_flag <= 1'b0;
            seq           <= '0;
        end else begin
            // Clear drops the flag; the REPORT-entry branch below overrides it
            if (clear) begin
                deadlock_flag <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (block_in) begin
                        state <= StCount;
                    end
                end
                StCount: begin
                    if (!block_in) begin
                        state <= StIdle;
                    end else if (cnt_term) begin
                        state                              <= StReport;
                        report_data[AXIS_LSB +: NUM_AXIS]  <= axis_block_sigs;
                        report_data[I_LSB +: NUM_INST]     <= inst_idle_sigs;
                        report_data[S_LSB +: SEQ_W]        <= seq;
                        report_valid                       <= 1'b1;
                        deadlock_flag                      <= 1'b1;
                        seq                                <= seq + SEQ_W'(1);
                    end
                end
                StReport: begin
                    // valid is always high here, so ready alone completes the handshake
                    if (report_ready) begin
                        report_valid <= 1'b0;
                        state        <= StHold;
                    end
                end
                StHold: begin
                    // Re-arm only once the block clears, or software forces it
                    if (!block_in || clear) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_rocca_s_deadlock_reporter.sv
// Directed, table-driven bench for rocca_s_deadlock_reporter with TIMEOUT=8.
module tb_rocca_s_deadlock_reporter;

    logic        clock = 1'b0;
    logic        reset;
    logic        block_in;
    logic [4:0]  axis_block_sigs;
    logic [3:0]  inst_idle_sigs;
    logic        clear;
    logic        report_valid;
    logic        report_ready;
    logic [16:0] report_data;
    logic        deadlock_flag;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    rocca_s_deadlock_reporter #(
        .NUM_AXIS (5),
        .NUM_INST (4),
        .TIMEOUT  (8),
        .CNT_W    (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .block_in        (block_in),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .clear           (clear),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_data     (report_data),
        .deadlock_flag   (deadlock_flag),
        .state_dbg       (state_dbg)
    );

    typedef struct {
        logic        blk;
        logic [4:0]  axis;
        logic [3:0]  inst;
        logic        clr;
        logic        rdy;
        logic        ev;
        logic        ef;
        logic [1:0]  es;
        logic [16:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic blk, input logic [4:0] axis, input logic [3:0] inst,
                       input logic clr, input logic rdy, input logic ev, input logic ef,
                       input logic [1:0] es, input logic [16:0] ed);
        vec_t v;
        v.blk = blk; v.axis = axis; v.inst = inst; v.clr = clr; v.rdy = rdy;
        v.ev = ev; v.ef = ef; v.es = es; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [16:0] mk_data(input int s, input logic [3:0] inst,
                                            input logic [4:0] axis);
        logic [7:0] s8;
        s8 = 8'(s);
        return {s8, inst, axis};
    endfunction

    initial begin
        reset = 1'b1; block_in = 1'b0; axis_block_sigs = '0; inst_idle_sigs = '0;
        clear = 1'b0; report_ready = 1'b0;

        // Scenario 1: reset for 3 cycles
        repeat (3) tick();
        check("rst_valid", 32'(report_valid), 32'd0);
        check("rst_flag", 32'(deadlock_flag), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_data", 32'(report_data), 32'd0);
        reset = 1'b0;

        // Scenario 2: 7 high cycles then low, no report
        for (int k = 0; k < 7; k++) add(1'b1, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 17'd0);
        add(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 17'd0);
        // Scenario 3: report after the 8th high edge, immediate handshake
        for (int k = 0; k < 7; k++)
            add(1'b1, 5'b01000, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 17'd0);
        add(1'b1, 5'b01000, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 17'h00068);
        add(1'b1, 5'b01000, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 17'h00068);
        add(1'b1, 5'b01000, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 17'h00068);
        add(1'b0, 5'b01000, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 17'h00068);

        foreach (vecs[i]) begin
            block_in = vecs[i].blk; axis_block_sigs = vecs[i].axis;
            inst_idle_sigs = vecs[i].inst; clear = vecs[i].clr; report_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(report_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_flag", i), 32'(deadlock_flag), 32'(vecs[i].ef));
            check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].es));
            check($sformatf("vec%0d_data", i), 32'(report_data), 32'(vecs[i].ed));
        end

        // Scenario 4: back-pressure for 20 cycles with block dropped and clear pulsed
        block_in = 1'b1; report_ready = 1'b0;
        axis_block_sigs = 5'b01000; inst_idle_sigs = 4'b0011;
        repeat (8) tick();
        check("s4_valid", 32'(report_valid), 32'd1);
        check("s4_data", 32'(report_data), 32'h00268);
        check("s4_state", 32'(state_dbg), 32'd2);
        for (int w = 1; w <= 20; w++) begin
            block_in = 1'b0;
            clear = (w == 5);
            axis_block_sigs = 5'(w * 7);
            inst_idle_sigs = 4'(w * 3);
            tick();
            check($sformatf("s4_wait%0d_valid", w), 32'(report_valid), 32'd1);
            check($sformatf("s4_wait%0d_data", w), 32'(report_data), 32'h00268);
            check($sformatf("s4_wait%0d_state", w), 32'(state_dbg), 32'd2);
            check($sformatf("s4_wait%0d_flag", w), 32'(deadlock_flag), (w < 5) ? 32'd1 : 32'd0);
        end
        clear = 1'b0; report_ready = 1'b1;
        tick();
        check("s4_hs_state", 32'(state_dbg), 32'd3);
        check("s4_hs_valid", 32'(report_valid), 32'd0);
        tick();
        check("s4_idle_state", 32'(state_dbg), 32'd0);

        // Scenario 5: 257 episodes, sequence number wraps
        reset = 1'b1; report_ready = 1'b0; block_in = 1'b0;
        tick();
        reset = 1'b0;
        for (int ep = 0; ep < 257; ep++) begin
            logic [4:0] ax;
            logic [3:0] in;
            ax = 5'(ep);
            in = 4'(ep >> 3);
            axis_block_sigs = ax; inst_idle_sigs = in; report_ready = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                block_in = 1'b1;
                clear = (ep == 0) && (k == 8);
                tick();
                if (k == 7) check($sformatf("s5_ep%0d_early", ep), 32'(report_valid), 32'd0);
            end
            clear = 1'b0;
            check($sformatf("s5_ep%0d_valid", ep), 32'(report_valid), 32'd1);
            check($sformatf("s5_ep%0d_data", ep), 32'(report_data), 32'(mk_data(ep, in, ax)));
            if (ep == 0) check("s5_set_beats_clear", 32'(deadlock_flag), 32'd1);
            tick();
            check($sformatf("s5_ep%0d_hold", ep), 32'(state_dbg), 32'd3);
            block_in = 1'b0;
            tick();
            check($sformatf("s5_ep%0d_idle", ep), 32'(state_dbg), 32'd0);
        end

        // Scenario 6: reset while a report is pending
        block_in = 1'b1; report_ready = 1'b0;
        axis_block_sigs = 5'b10101; inst_idle_sigs = 4'b1010;
        repeat (8) tick();
        check("s6_pending", 32'(report_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("s6_valid", 32'(report_valid), 32'd0);
        check("s6_state", 32'(state_dbg), 32'd0);
        check("s6_flag", 32'(deadlock_flag), 32'd0);
        check("s6_data", 32'(report_data), 32'd0);
        reset = 1'b0;
        repeat (8) tick();
        check("s6_seq", 32'(report_data), 32'(mk_data(0, 4'b1010, 5'b10101)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
